wave_gen_bank: RTL and testbench
================================

// Module: wave_gen_bank
// PURPOSE
//  Registered bank of three 14-bit DAC waveform generators: sawtooth, square and sine.
//  Sits between the top-level sample counter / phase accumulator and the DAC output mux.
//  Saw and square derive from the free-running sample counter; sine is a LUT lookup on
//  the phase accumulator. Each generator has its own enable; a disabled generator outputs 0.
// PARAMETERS
//  DATA_W   14  DAC sample width; also width of cnt. Only 14 is required to be supported.
//  PHASE_W  16  phase accumulator width (addr).
//  LUT_AW    8  sine table index width; the index is addr[PHASE_W-1 -: LUT_AW].
// PORTS
//  clk      in   1        sample clock; all state updates on its rising edge
//  rst      in   1        asynchronous reset, active-high
//  cnt      in   DATA_W   free-running sample counter (wraps 16383->0)
//  addr     in   PHASE_W  phase accumulator value
//  en       in   3        enables: [0]=saw, [1]=square, [2]=sine
//  saw_out  out  DATA_W   sawtooth sample
//  sqr_out  out  DATA_W   square sample
//  sin_out  out  DATA_W   sine sample, offset binary
// BEHAVIOUR
//  - Interface: one clock (clk). rst is asynchronous and active-high.
//  - While rst=1, saw_out, sqr_out and sin_out are 0, regardless of clk.
//  - After rst deasserts, the first update occurs on the next rising edge.
//  - Every output is registered. Latency is 1 clk from cnt/addr/en to the output.
//    There is no handshake and no backpressure. Each generator produces a new sample every cycle.
//  - Enable gating is per output:
//    - en[i]=0 at an edge -> that output is 0 after the edge.
//    - en[i]=1 -> that output follows its formula.
//    - Toggling en mid-stream takes effect on the next edge and affects no other output.
//  - Saw: saw_out <= cnt.
//    - Ramps 0..16383 while cnt increments, then drops to 0 on counter wrap.
//  - Square: sqr_out <= cnt[DATA_W-1] ? {DATA_W{1'b1}} : 0.
//    - cnt 0..8191 -> 0; cnt 8192..16383 -> 16383.
//    - 50% duty cycle; period equals the cnt wrap period.
//  - Sine:
//    - k = addr[15:8] (0..255); sin_out <= MID + round(AMP*sin(2*pi*k/256)).
//    - MID = 2^(DATA_W-1) = 8192, AMP = MID-1 = 8191.
//    - round() is round-half-away-from-zero.
//    - Output range is 1..16383; the value 0 is only produced by disable or reset.
//    - Anchor points: k=0 -> 8192; k=64 -> 16383; k=128 -> 8192; k=192 -> 1.
//    - addr[7:0] is ignored (no interpolation).
//    - Table may be full (256 entries) or quarter-wave (65 entries Q[0..64]) with symmetry:
//      k<=64: MID+Q[k]; 64<k<=128: MID+Q[128-k];
//      128<k<=192: MID-Q[k-128]; k>192: MID-Q[256-k].
//      Both forms must give bit-identical results.
//  - Frequency is set entirely by the caller's addr step.
//    - Example: step 1321 -> the index advances about 5.16 per clk.
//    - The block keeps no phase state of its own.
//    - Wrap of addr (0xFFFF->0x0000) is seamless: k 255 -> 0.
//  - Simultaneous events: rst dominates en and all data.
//    - Every output is independent; any combination of enables is legal, including all or none.
//  - No X propagation: outputs are defined for every cnt/addr value once out of reset.
// TESTING
//  1 Reset: rst=1 mid-run with en=3'b111 -> all outputs 0 immediately, without waiting for clk.
//    Release rst -> valid data one edge later.
//  2 Saw: en=001, cnt sweeps 16382,16383,0,1 -> saw_out 16382,16383,0,1 one clk late.
//    sqr_out and sin_out stay 0.
//  3 Square: en=010, cnt=8191 then 8192, then 16383 then 0 -> sqr_out 0,16383,16383,0.
//  4 Sine: en=100, addr=0x0000,0x4000,0x8000,0xC000,0x40FF -> sin_out 8192,16383,8192,1,16383.
//    Then a full sweep of addr[15:8] compared against the real-valued model for all 256 points.
//  5 Enable toggling: all three enabled; drop en[1] for one cycle -> only sqr_out is 0
//    for exactly that one sample; the others are unaffected.
//  6 Wrap: addr stepping by 1321 across 0xFFFF with en=100 -> sin_out continuous,
//    matching the model at every sample.

Source files
------------

// File: rtl/wave_gen_bank_if.sv
// ---------------------------------------------------------------------------
// wave_gen_bank_if
// Sample-rate bus between the sample counter / phase accumulator (master side)
// and the waveform generator bank (slave side). There is no handshake; every
// field is sampled or updated once per clock.
//
//   cnt      master->slave  DATA_W   free-running sample counter
//   addr     master->slave  PHASE_W  phase accumulator value
//   en       master->slave  3        enables: [0]=saw, [1]=square, [2]=sine
//   saw_out  slave->master  DATA_W   sawtooth sample
//   sqr_out  slave->master  DATA_W   square sample
//   sin_out  slave->master  DATA_W   sine sample, offset binary
// ---------------------------------------------------------------------------
interface wave_gen_bank_if #(
    parameter int DATA_W  = 14,
    parameter int PHASE_W = 16
);
    logic [DATA_W-1:0]  cnt;
    logic [PHASE_W-1:0] addr;
    logic [2:0]         en;
    logic [DATA_W-1:0]  saw_out;
    logic [DATA_W-1:0]  sqr_out;
    logic [DATA_W-1:0]  sin_out;

    modport master (
        output cnt, addr, en,
        input  saw_out, sqr_out, sin_out
    );

    modport slave (
        input  cnt, addr, en,
        output saw_out, sqr_out, sin_out
    );
endinterface

// File: rtl/wave_gen_bank.sv
// ---------------------------------------------------------------------------
// wave_gen_bank
// Registered bank of three DAC waveform generators (sawtooth, square, sine).
// Saw and square are derived from the caller's sample counter, sine is a
// quarter-wave table lookup on the top LUT_AW bits of the caller's phase
// accumulator. Each output is registered (1 clk latency) and forced to 0
// when its enable is low or while rst is high.
//
// Ports
//   clk  in   sample clock, rising edge
//   rst  in   asynchronous reset, active-high; clears all outputs
//   bus  slave modport of wave_gen_bank_if (cnt, addr, en in; three samples out)
// ---------------------------------------------------------------------------
module wave_gen_bank #(
    parameter int DATA_W  = 14,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    wave_gen_bank_if.slave  bus
);

    localparam int QN = 1 << (LUT_AW - 2);                  // quarter-wave points
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

    // Quarter-wave entry round(AMP * sin(pi/2 * k/QN)), evaluated at
    // elaboration with a Q30 fixed-point Taylor series so the table holds
    // plain constants. 12 terms leave the error far below one LSB.
    function automatic logic [DATA_W-2:0] q_entry(input int k);
        longint pi_q30;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint amp;
        longint q;
        pi_q30 = 64'sd3373259426;
        x      = (longint'(k) * pi_q30 + (64'sd1 <<< (LUT_AW - 2))) >>> (LUT_AW - 1);
        x2     = (x * x) >>> 30;
        term   = x;
        s      = x;
        for (int n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / (longint'(2 * n) * longint'(2 * n + 1)));
            s    = s + term;
        end
        amp = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
        q   = (amp * s + (64'sd1 <<< 29)) >>> 30;
        if (q < 0) begin
            q = 0;
        end
        if (q > amp) begin
            q = amp;
        end
        return q[DATA_W-2:0];
    endfunction

    logic [DATA_W-2:0] q_tab [0:QN];

    for (genvar g = 0; g <= QN; g++) begin : g_qtab
        assign q_tab[g] = q_entry(g);
    end

    // Fine phase bits below the table index do not take part (no interpolation).
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.addr[PHASE_W-LUT_AW-1:0];

    logic [LUT_AW-1:0] k;
    logic [1:0]        quad;
    logic [LUT_AW-3:0] low;
    logic [LUT_AW-2:0] idx;
    logic [DATA_W-2:0] q_mag;
    logic [DATA_W-1:0] sin_val;

    logic [DATA_W-1:0] saw_d, saw_q;
    logic [DATA_W-1:0] sqr_d, sqr_q;
    logic [DATA_W-1:0] sin_d, sin_q;

    // Quadrants 1 and 3 walk the table backwards (QN-low); quadrants 2 and 3
    // sit below MID. Reaching index QN from quadrant 1/3 with low=0 covers the
    // peak points (k=64 and k=192) exactly.
    always_comb begin
        k    = bus.addr[PHASE_W-1 -: LUT_AW];
        quad = k[LUT_AW-1 -: 2];
        low  = k[LUT_AW-3:0];
        idx  = quad[0] ? ((LUT_AW-1)'(QN) - {1'b0, low}) : {1'b0, low};
        q_mag = q_tab[idx];
        if (quad[1]) begin
            sin_val = MID - {1'b0, q_mag};
        end else begin
            sin_val = MID + {1'b0, q_mag};
        end
    end

    always_comb begin
        saw_d = '0;
        sqr_d = '0;
        sin_d = '0;
        if (bus.en[0]) begin
            saw_d = bus.cnt;
        end
        if (bus.en[1] && bus.cnt[DATA_W-1]) begin
            sqr_d = '1;
        end
        if (bus.en[2]) begin
            sin_d = sin_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saw_q <= '0;
            sqr_q <= '0;
            sin_q <= '0;
        end else begin
            saw_q <= saw_d;
            sqr_q <= sqr_d;
            sin_q <= sin_d;
        end
    end

    assign bus.saw_out = saw_q;
    assign bus.sqr_out = sqr_q;
    assign bus.sin_out = sin_q;

endmodule

// File: tb/tb_wave_gen_bank.sv
// ---------------------------------------------------------------------------
// tb_wave_gen_bank
// Directed bench for wave_gen_bank. Inputs change 1 ns after a rising edge,
// outputs are sampled 1 ns after the following rising edge. Sine expectations
// come from a real-valued model using $sin with round-half-away-from-zero.
// ---------------------------------------------------------------------------
module tb_wave_gen_bank;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    wave_gen_bank_if #(.DATA_W(14), .PHASE_W(16)) bus ();

    wave_gen_bank #(.DATA_W(14), .PHASE_W(16), .LUT_AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sin_model(input int kk);
        real r;
        int  ri;
        r = 8191.0 * $sin(2.0 * 3.14159265358979323846 * kk / 256.0);
        if (r >= 0.0) ri = $rtoi($floor(r + 0.5));
        else          ri = -$rtoi($floor(-r + 0.5));
        return 8192 + ri;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e_saw, input int e_sqr, input int e_sin);
        chk({tag, ".saw"}, int'(bus.saw_out), e_saw);
        chk({tag, ".sqr"}, int'(bus.sqr_out), e_sqr);
        chk({tag, ".sin"}, int'(bus.sin_out), e_sin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          cnt_v  [4];
    int          sqr_v  [4];
    int          sqr_e  [4];
    logic [15:0] a_v    [5];
    int          a_e    [5];
    logic [15:0] a;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.cnt  = 14'd0;
        bus.addr = 16'd0;
        bus.en   = 3'b000;

        // Reset state
        tick();
        chk_all("rst0", 0, 0, 0);

        // Release with all enabled: valid one edge later
        rst = 1'b0;
        bus.en   = 3'b111;
        bus.cnt  = 14'd9000;
        bus.addr = 16'h4000;
        tick();
        chk_all("rel", 9000, 16383, 16383);

        // Mid-run async reset, seen without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 0, 0, 0);
        tick();
        chk_all("arst_edge", 0, 0, 0);
        rst = 1'b0;
        bus.cnt = 14'd100;
        tick();
        chk_all("arst_rel", 100, 0, 16383);

        // Saw across counter wrap
        cnt_v = '{16382, 16383, 0, 1};
        bus.en   = 3'b001;
        bus.addr = 16'h4000;
        for (int i = 0; i < 4; i++) begin
            bus.cnt = 14'(cnt_v[i]);
            tick();
            chk_all($sformatf("saw%0d", i), cnt_v[i], 0, 0);
        end

        // Square around both transitions
        sqr_v = '{8191, 8192, 16383, 0};
        sqr_e = '{0, 16383, 16383, 0};
        bus.en = 3'b010;
        for (int i = 0; i < 4; i++) begin
            bus.cnt = 14'(sqr_v[i]);
            tick();
            chk_all($sformatf("sqr%0d", i), 0, sqr_e[i], 0);
        end

        // Sine anchors
        a_v = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h40FF};
        a_e = '{8192, 16383, 8192, 1, 16383};
        bus.en  = 3'b100;
        bus.cnt = 14'd12000;
        for (int i = 0; i < 5; i++) begin
            bus.addr = a_v[i];
            tick();
            chk_all($sformatf("sin_anchor%0d", i), 0, 0, a_e[i]);
        end

        // Full table sweep against the real-valued model
        for (int kk = 0; kk < 256; kk++) begin
            bus.addr = {8'(kk), 8'h5A};
            tick();
            chk($sformatf("sin_k%0d", kk), int'(bus.sin_out), sin_model(kk));
        end

        // Drop en[1] for one sample only
        bus.en   = 3'b111;
        bus.cnt  = 14'd9000;
        bus.addr = 16'h2000;
        tick();
        chk_all("tog0", 9000, 16383, sin_model(8'h20));
        bus.en   = 3'b101;
        bus.cnt  = 14'd9001;
        bus.addr = 16'h2100;
        tick();
        chk_all("tog1", 9001, 0, sin_model(8'h21));
        bus.en   = 3'b111;
        bus.cnt  = 14'd9002;
        bus.addr = 16'h2200;
        tick();
        chk_all("tog2", 9002, 16383, sin_model(8'h22));

        // Phase wrap with step 1321
        bus.en = 3'b100;
        a = 16'hE000;
        for (int i = 0; i < 20; i++) begin
            bus.addr = a;
            tick();
            chk($sformatf("wrap%0d", i), int'(bus.sin_out), sin_model(int'(a[15:8])));
            a = a + 16'd1321;
        end

        // No enables at all
        bus.en   = 3'b000;
        bus.cnt  = 14'd16000;
        bus.addr = 16'h4000;
        tick();
        chk_all("none", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
